// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that pulls 24-bit words from two normal-mode FIFOs and
// sends each as a five-byte UART frame: header, H, M, L, checksum.
module uart_frame_arbiter #(
  parameter logic [7:0] HDR0 = 8'hA5,
  parameter logic [7:0] HDR1 = 8'hB6
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enable,
  input  logic        empty0,
  input  logic        empty1,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  output logic        rdreq0,
  output logic        rdreq1,
  input  logic        ready,
  output logic        rdy,
  output logic [7:0]  UART_data,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [3:0] {
    IDLE, REQ, WAIT, LATCH, S_HDR, S_H, S_M, S_L, S_CHK
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  h_q, h_d, m_q, m_d, l_q, l_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q;
  logic [15:0] frames_q, frames_d;

  logic [7:0]  hdr;
  logic [7:0]  chk;
  logic [7:0]  byte_sel;
  logic        tx_state;
  logic        can_issue;

  assign hdr       = grant_q ? HDR1 : HDR0;
  assign chk       = hdr + h_q + m_q + l_q;
  assign tx_state  = state_q inside {S_HDR, S_H, S_M, S_L, S_CHK};
  // A strobe is never issued back to back; the transmitter needs a cycle to drop ready.
  assign can_issue = ready && !rdy_q;

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    h_d      = h_q;
    m_d      = m_q;
    l_d      = l_q;
    data_d   = data_q;
    frames_d = frames_q;
    rdreq0   = 1'b0;
    rdreq1   = 1'b0;
    rdy      = 1'b0;
    byte_sel = 8'h00;

    case (state_q)
      IDLE: begin
        if (enable && (!empty0 || !empty1)) begin
          grant_d = (!empty0 && !empty1) ? ~last_q : empty0;
          state_d = REQ;
        end
      end
      REQ: begin
        rdreq0  = ~grant_q;
        rdreq1  = grant_q;
        state_d = WAIT;
      end
      WAIT:  state_d = LATCH;
      LATCH: begin
        {h_d, m_d, l_d} = grant_q ? data1 : data0;
        state_d         = S_HDR;
      end
      S_HDR: begin
        byte_sel = hdr;
        if (can_issue) state_d = S_H;
      end
      S_H: begin
        byte_sel = h_q;
        if (can_issue) state_d = S_M;
      end
      S_M: begin
        byte_sel = m_q;
        if (can_issue) state_d = S_L;
      end
      S_L: begin
        byte_sel = l_q;
        if (can_issue) state_d = S_CHK;
      end
      S_CHK: begin
        byte_sel = chk;
        if (can_issue) begin
          state_d  = IDLE;
          frames_d = frames_q + 16'd1;
          last_d   = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_state && can_issue) begin
      rdy    = 1'b1;
      data_d = byte_sel;
    end
  end

  // NOTE: state registers use non-blocking assignments and the asynchronous reset clears every register, captured bytes included.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      h_q      <= 8'h00;
      m_q      <= 8'h00;
      l_q      <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b0;
      frames_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      h_q      <= h_d;
      m_q      <= m_d;
      l_q      <= l_d;
      data_q   <= data_d;
      rdy_q    <= rdy;
      frames_q <= frames_d;
    end
  end

  // The byte appears in the same cycle as its strobe and is held until the next one.
  assign UART_data   = rdy ? byte_sel : data_q;
  assign busy        = (state_q != IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: FIFO models feed the DUT and a queue-based
// reference model predicts grant order and the byte stream of every frame.
module tb_uart_frame_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        ready = 1'b0;
  logic        empty0, empty1;
  logic [23:0] data0 = 24'h0, data1 = 24'h0;
  logic        rdreq0, rdreq1, rdy, busy;
  logic [7:0]  UART_data;
  logic [15:0] frames_sent;

  always #5 CLK = ~CLK;

  uart_frame_arbiter dut (
    .CLK(CLK), .reset(reset), .enable(enable),
    .empty0(empty0), .empty1(empty1), .data0(data0), .data1(data1),
    .rdreq0(rdreq0), .rdreq1(rdreq1), .ready(ready), .rdy(rdy),
    .UART_data(UART_data), .busy(busy), .frames_sent(frames_sent)
  );

  // Normal-mode FIFO models: read data appears the cycle after rdreq.
  logic [23:0] mem0 [256];
  logic [23:0] mem1 [256];
  logic [7:0]  wr0 = 8'd0, wr1 = 8'd0, rd0 = 8'd0, rd1 = 8'd0;
  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);

  always @(posedge CLK) begin
    if (rdreq0) begin data0 <= mem0[rd0]; rd0 <= rd0 + 8'd1; end
    if (rdreq1) begin data1 <= mem1[rd1]; rd1 <= rd1 + 8'd1; end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model state.
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [7:0]  exp_bytes[$];
  logic        exp_grant[$];
  logic        m_last = 1'b1;
  int          exp_frames = 0;

  int          n_vec = 0, n_err = 0;
  int          strobes_seen = 0, strobe_cyc = 0, rdreq_seen = 0;
  logic [7:0]  last_byte = 8'h00;
  logic        prev_rdy = 1'b0;
  logic        rand_ready = 1'b0, ready_force = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic push_word(input logic ch, input logic [23:0] w);
    if (!ch) begin mem0[wr0] = w; wr0 = wr0 + 8'd1; q0.push_back(w); end
    else     begin mem1[wr1] = w; wr1 = wr1 + 8'd1; q1.push_back(w); end
  endtask

  // One frame by the arbitration and framing rules, with plain integer arithmetic.
  function automatic void predict_one();
    logic        ch;
    logic [23:0] w;
    int          hdr, sum;
    if (q0.size() == 0 && q1.size() == 0) return;
    if (q0.size() != 0 && q1.size() != 0) ch = !m_last;
    else                                   ch = (q0.size() == 0);
    w   = ch ? q1.pop_front() : q0.pop_front();
    hdr = ch ? 32'hB6 : 32'hA5;
    sum = hdr + int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
    exp_grant.push_back(ch);
    exp_bytes.push_back(8'(hdr));
    exp_bytes.push_back(w[23:16]);
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[7:0]);
    exp_bytes.push_back(8'(sum % 256));
    m_last = ch;
    exp_frames++;
  endfunction

  function automatic void predict_all();
    while (q0.size() != 0 || q1.size() != 0) predict_one();
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK); #1;
      if (exp_bytes.size() == 0 && !busy) begin done = 1'b1; break; end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_frames"}, 32'(frames_sent), 32'(exp_frames));
  endtask

  task automatic wait_strobes(input int target);
    logic ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge CLK); #1;
      if (strobes_seen >= target) begin ok = 1'b1; break; end
    end
    check("strobe_wait", 32'(ok), 32'd1);
  endtask

  // Ready driver, updated mid-cycle so it is stable at every sampling point.
  initial forever begin
    @(posedge CLK); #2;
    ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: strobes, read requests and held data compared against the model.
  initial forever begin
    logic [1:0] want_rq;
    logic [8:0] want_tx;
    @(negedge CLK);
    if (reset) begin
      exp_bytes.delete();
      exp_grant.delete();
      last_byte = 8'h00;
    end
    if (rdreq0 || rdreq1) begin
      rdreq_seen++;
      want_rq = (exp_grant.size() == 0) ? 2'b00 : (exp_grant.pop_front() ? 2'b10 : 2'b01);
      check("rdreq_ch", 32'({rdreq1, rdreq0}), 32'(want_rq));
    end
    if (rdy) begin
      strobes_seen++;
      strobe_cyc = cyc;
      check("rdy_ready", 32'(ready), 32'd1);
      check("rdy_spacing", 32'(prev_rdy), 32'd0);
      want_tx = (exp_bytes.size() == 0) ? 9'h000 : {1'b1, exp_bytes.pop_front()};
      check("tx_byte", 32'({rdy, UART_data}), 32'(want_tx));
      if (want_tx[8]) last_byte = want_tx[7:0];
    end else begin
      check("tx_hold", 32'(UART_data), 32'(last_byte));
    end
    prev_rdy = rdy;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, start, s0, r0, c0, c1;
    #1;
    reset = 1'b1;
    enable = 1'b1;
    ready_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_word(1'b0, 24'($urandom));
      push_word(1'b1, 24'($urandom));
    end
    tick(4);
    check("rst_rdreq", 32'({rdreq1, rdreq0}), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_data", 32'(UART_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);

    // Both channels loaded: grants alternate starting with channel 0.
    reset = 1'b0;
    predict_all();
    wait_idle("rr6");
    check("rr6_rdreqs", 32'(rdreq_seen), 32'd6);

    // Single word on channel 0, minimum latency to the first strobe.
    enable = 1'b0;
    push_word(1'b0, 24'h123456);
    predict_all();
    tick(2);
    base = strobes_seen;
    enable = 1'b1;
    start = cyc;
    wait_strobes(base + 1);
    check("latency", 32'(strobe_cyc - start), 32'd4);
    wait_idle("ch0_123456");

    // Checksum wrap on an all-ones word.
    push_word(1'b1, 24'hFFFFFF);
    predict_all();
    wait_idle("ch1_ffffff");

    // Transmitter stalls in S_M.
    push_word(1'b0, 24'hC0FFEE);
    predict_all();
    base = strobes_seen;
    wait_strobes(base + 2);
    ready_force = 1'b0;
    s0 = strobes_seen;
    tick(10);
    check("stall_no_rdy", 32'(strobes_seen - s0), 32'd0);
    check("stall_data", 32'(UART_data), 32'hC0);
    ready_force = 1'b1;
    wait_idle("stall");

    // Reset in S_M abandons the frame.
    push_word(1'b0, 24'h0A0B0C);
    predict_all();
    base = strobes_seen;
    wait_strobes(base + 2);
    ready_force = 1'b0;
    tick(3);
    reset = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(rdy), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frames", 32'(frames_sent), 32'd0);
    check("mid_rst_data", 32'(UART_data), 32'd0);
    m_last = 1'b1;
    exp_frames = 0;
    tick(2);
    reset = 1'b0;
    ready_force = 1'b1;
    push_word(1'b1, 24'h5A5A5A);
    push_word(1'b0, 24'h010203);
    predict_all();
    wait_idle("post_rst");

    // Enable low blocks new frames; dropping it mid-frame lets the frame finish.
    enable = 1'b0;
    push_word(1'b0, 24'hABCDEF);
    push_word(1'b1, 24'h13579B);
    r0 = rdreq_seen;
    tick(20);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_rdreq", 32'(rdreq_seen - r0), 32'd0);
    predict_one();
    base = strobes_seen;
    enable = 1'b1;
    wait_strobes(base + 1);
    enable = 1'b0;
    wait_idle("en_drop");
    r0 = rdreq_seen;
    tick(20);
    check("en_drop_busy", 32'(busy), 32'd0);
    check("en_drop_rdreq", 32'(rdreq_seen - r0), 32'd0);
    enable = 1'b1;
    predict_all();
    wait_idle("en_resume");

    // Randomized loads with a randomly stalling transmitter.
    rand_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      enable = 1'b0;
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      for (int i = 0; i < c0; i++) push_word(1'b0, 24'($urandom));
      for (int i = 0; i < c1; i++) push_word(1'b1, 24'($urandom));
      predict_all();
      tick(1);
      enable = 1'b1;
      wait_idle("rand");
    end
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
